// File: rtl/dsp_accum.sv
// Frame accumulator: sums unsigned dsp_slice terms until a last-flagged beat,
// then holds the sum, term count and overflow flag for a valid/ready hand-over.
module dsp_accum #(
  parameter int data_width = 8,
  parameter int acc_width  = 2*data_width+8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*data_width-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [acc_width-1:0]    out_data,
  output logic [7:0]              out_count,
  output logic                    out_ovf
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t               state_q, state_d;
  logic [acc_width-1:0] acc_q, acc_d;
  logic [7:0]           count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 first_q, first_d;
  logic [acc_width-1:0] out_data_q, out_data_d;
  logic [7:0]           out_count_q, out_count_d;
  logic                 out_ovf_q, out_ovf_d;

  logic                 beat;
  logic [acc_width:0]   sum_full;

  assign in_ready  = (state_q == ACCUM) || out_ready;
  assign beat      = in_valid && in_ready;
  assign sum_full  = (acc_width+1)'(acc_q) + (acc_width+1)'(in_data);

  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  // first_q marks that the next accepted beat opens a new frame; it is set by
  // every last beat, so a beat accepted while in HOLD always starts fresh.
  always_comb begin
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    first_d     = first_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    if (beat) begin
      first_d = in_last;
      if (first_q) begin
        acc_d   = acc_width'(in_data);
        count_d = 8'd1;
        ovf_d   = 1'b0;
      end else begin
        acc_d   = sum_full[acc_width-1:0];
        ovf_d   = ovf_q | sum_full[acc_width];
        count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
      end
      if (in_last) begin
        out_data_d  = acc_d;
        out_count_d = count_d;
        out_ovf_d   = ovf_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: if (beat && in_last) state_d = HOLD;
      HOLD:  if (out_ready) state_d = (beat && in_last) ? HOLD : ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      first_q     <= 1'b1;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      first_q     <= first_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule
